// File: rtl/eth_pcs_rx_descrambler_if.sv
// Gearbox-to-decoder bus for the RX descrambler.
//   i_grbx_hdr_valid / i_grbx_hdr   : sync header strobe and value (bit0 first)
//   i_grbx_data_valid / i_grbx_data : scrambled data word strobe and value
//   i_rx_lock                       : block lock from the block synchronizer
//   o_dscr_valid/first/hdr/err/data : aligned, descrambled word plus block flags
// slave  = descrambler view, master = upstream/downstream (bench) view.
interface eth_pcs_rx_descrambler_if #(
  parameter int W_DATA = 32,
  parameter int W_SYNC = 2
);
  logic              i_grbx_hdr_valid;
  logic [W_SYNC-1:0] i_grbx_hdr;
  logic              i_grbx_data_valid;
  logic [W_DATA-1:0] i_grbx_data;
  logic              i_rx_lock;
  logic              o_dscr_valid;
  logic              o_dscr_first;
  logic [W_SYNC-1:0] o_dscr_hdr;
  logic              o_dscr_err;
  logic [W_DATA-1:0] o_dscr_data;

  modport slave (
    input  i_grbx_hdr_valid, i_grbx_hdr, i_grbx_data_valid, i_grbx_data, i_rx_lock,
    output o_dscr_valid, o_dscr_first, o_dscr_hdr, o_dscr_err, o_dscr_data
  );

  modport master (
    output i_grbx_hdr_valid, i_grbx_hdr, i_grbx_data_valid, i_grbx_data, i_rx_lock,
    input  o_dscr_valid, o_dscr_first, o_dscr_hdr, o_dscr_err, o_dscr_data
  );
endinterface

// File: rtl/eth_pcs_rx_descrambler.sv
// 64b/66b receive descrambler (x^58 + x^39 + 1, self-synchronizing).
// Removes scrambling from the gearbox data stream and re-attaches each sync
// header to the data words of its block. One cycle of latency, no backpressure.
// Ports:
//   i_clk   : clock
//   i_reset : synchronous active-high reset
//   bus     : gearbox inputs, lock, and descrambled outputs (slave modport)
module eth_pcs_rx_descrambler #(
  parameter int W_DATA        = 32,
  parameter int W_SYNC        = 2,
  parameter int TRANS_PER_BLK = 64 / W_DATA,
  parameter bit DSCR_BYPASS   = 1'b0
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  eth_pcs_rx_descrambler_if.slave    bus
);
  localparam int CW = (TRANS_PER_BLK > 1) ? $clog2(TRANS_PER_BLK) : 1;
  localparam logic [CW-1:0] LAST = CW'(TRANS_PER_BLK - 1);
  localparam logic [CW-1:0] CNT_AFTER_FIRST = (TRANS_PER_BLK == 1) ? '0 : CW'(1);

  logic [57:0]        state;     // state[57] = most recently received bit
  logic [W_DATA+57:0] ext;
  logic [W_DATA-1:0]  dscr;
  logic [CW-1:0]      word_cnt;
  logic               hdr_pend;
  logic [W_SYNC-1:0]  pend_hdr;
  logic [W_SYNC-1:0]  held_hdr;
  logic [W_SYNC-1:0]  new_hdr;
  logic               accept;

  function automatic logic bad_hdr(input logic [W_SYNC-1:0] h);
    return (h == '0) || (&h);
  endfunction

  // Scrambler taps are 39 and 58 bits back in the received stream.
  always_comb begin
    ext  = {bus.i_grbx_data, state};
    dscr = '0;
    for (int i = 0; i < W_DATA; i++)
      dscr[i] = DSCR_BYPASS ? bus.i_grbx_data[i]
                            : bus.i_grbx_data[i] ^ ext[i+19] ^ ext[i];
  end

  assign accept  = bus.i_grbx_data_valid & bus.i_rx_lock;
  // A header arriving with the word frames that same word.
  assign new_hdr = bus.i_grbx_hdr_valid ? bus.i_grbx_hdr : pend_hdr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state            <= '0;
      word_cnt         <= '0;
      hdr_pend         <= 1'b0;
      pend_hdr         <= '0;
      held_hdr         <= '0;
      bus.o_dscr_valid <= 1'b0;
      bus.o_dscr_first <= 1'b0;
      bus.o_dscr_hdr   <= '0;
      bus.o_dscr_err   <= 1'b0;
      bus.o_dscr_data  <= '0;
    end else begin
      // Self-synchronizing: keep tracking the line even while unlocked.
      if (bus.i_grbx_data_valid) state <= ext[W_DATA+57:W_DATA];
      bus.o_dscr_valid <= accept;

      if (!bus.i_rx_lock) begin
        word_cnt <= '0;
        hdr_pend <= 1'b0;
      end else if (accept) begin
        bus.o_dscr_data <= dscr;
        if (bus.i_grbx_hdr_valid || hdr_pend) begin
          // Also covers a header that arrived mid-block: old block is dropped.
          bus.o_dscr_first <= 1'b1;
          bus.o_dscr_hdr   <= new_hdr;
          bus.o_dscr_err   <= bad_hdr(new_hdr);
          held_hdr         <= new_hdr;
          word_cnt         <= CNT_AFTER_FIRST;
          hdr_pend         <= 1'b0;
        end else if (word_cnt != '0) begin
          bus.o_dscr_first <= 1'b0;
          bus.o_dscr_hdr   <= held_hdr;
          bus.o_dscr_err   <= bad_hdr(held_hdr);
          word_cnt         <= (word_cnt == LAST) ? '0 : word_cnt + CW'(1);
        end else begin
          // Orphan: no header framed this word.
          bus.o_dscr_first <= 1'b0;
          bus.o_dscr_hdr   <= held_hdr;
          bus.o_dscr_err   <= 1'b1;
        end
      end else if (bus.i_grbx_hdr_valid) begin
        hdr_pend <= 1'b1;
        pend_hdr <= bus.i_grbx_hdr;
      end
    end
  end
endmodule

// File: tb/tb_eth_pcs_rx_descrambler.sv
// Bench for eth_pcs_rx_descrambler: a normal and a bypass instance share the
// same stimulus; both are compared every cycle with a bit-serial stream model.
module tb_eth_pcs_rx_descrambler;
  localparam int W   = 32;
  localparam int TPB = 64 / W;

  logic i_clk = 1'b0;
  logic i_reset;
  always #5 i_clk = ~i_clk;

  eth_pcs_rx_descrambler_if #(.W_DATA(W), .W_SYNC(2)) dif ();
  eth_pcs_rx_descrambler_if #(.W_DATA(W), .W_SYNC(2)) bif ();

  assign bif.i_grbx_hdr_valid  = dif.i_grbx_hdr_valid;
  assign bif.i_grbx_hdr        = dif.i_grbx_hdr;
  assign bif.i_grbx_data_valid = dif.i_grbx_data_valid;
  assign bif.i_grbx_data       = dif.i_grbx_data;
  assign bif.i_rx_lock         = dif.i_rx_lock;

  eth_pcs_rx_descrambler #(.W_DATA(W), .W_SYNC(2), .TRANS_PER_BLK(TPB), .DSCR_BYPASS(1'b0))
    u_dut (.i_clk(i_clk), .i_reset(i_reset), .bus(dif.slave));
  eth_pcs_rx_descrambler #(.W_DATA(W), .W_SYNC(2), .TRANS_PER_BLK(TPB), .DSCR_BYPASS(1'b1))
    u_byp (.i_clk(i_clk), .i_reset(i_reset), .bus(bif.slave));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: whole received bit stream since reset, and block framing
  // described as "header pending" + "words still owed to the current block".
  bit         hist[$];
  bit         m_pend;
  logic [1:0] m_pend_hdr, m_blk_hdr;
  int         m_left;
  logic       m_v, m_f, m_e;
  logic [1:0] m_h;
  logic [W-1:0] m_d, m_bd;

  function automatic bit is_bad(input logic [1:0] h);
    return (h == 2'b00) || (h == 2'b11);
  endfunction

  task automatic model_step();
    logic [W-1:0] dout;
    logic [1:0]   h;
    int           n;
    if (i_reset) begin
      hist.delete();
      m_pend = 0; m_pend_hdr = '0; m_blk_hdr = '0; m_left = 0;
      m_v = 0; m_f = 0; m_e = 0; m_h = '0; m_d = '0; m_bd = '0;
      return;
    end
    dout = '0;
    if (dif.i_grbx_data_valid) begin
      for (int i = 0; i < W; i++) begin
        n = hist.size();
        hist.push_back(dif.i_grbx_data[i]);
        dout[i] = dif.i_grbx_data[i] ^ ((n >= 39) ? hist[n-39] : 1'b0)
                                     ^ ((n >= 58) ? hist[n-58] : 1'b0);
      end
    end
    m_v = dif.i_grbx_data_valid && dif.i_rx_lock;
    if (!dif.i_rx_lock) begin
      m_pend = 0;
      m_left = 0;
    end else if (m_v) begin
      m_d  = dout;
      m_bd = dif.i_grbx_data;
      if (dif.i_grbx_hdr_valid || m_pend) begin
        h = dif.i_grbx_hdr_valid ? dif.i_grbx_hdr : m_pend_hdr;
        m_blk_hdr = h; m_left = TPB - 1; m_pend = 0;
        m_f = 1; m_h = h; m_e = is_bad(h);
      end else if (m_left > 0) begin
        m_left--;
        m_f = 0; m_h = m_blk_hdr; m_e = is_bad(m_blk_hdr);
      end else begin
        m_f = 0; m_h = m_blk_hdr; m_e = 1;
      end
    end else if (dif.i_grbx_hdr_valid) begin
      m_pend = 1;
      m_pend_hdr = dif.i_grbx_hdr;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge i_clk);
    #1;
    chk("valid", dif.o_dscr_valid, m_v);
    chk("first", dif.o_dscr_first, m_f);
    chk("hdr",   dif.o_dscr_hdr,   m_h);
    chk("err",   dif.o_dscr_err,   m_e);
    chk("data",  dif.o_dscr_data,  m_d);
    chk("byp_valid", bif.o_dscr_valid, m_v);
    chk("byp_first", bif.o_dscr_first, m_f);
    chk("byp_hdr",   bif.o_dscr_hdr,   m_h);
    chk("byp_err",   bif.o_dscr_err,   m_e);
    chk("byp_data",  bif.o_dscr_data,  m_bd);
  endtask

  task automatic drive(input bit hv, input logic [1:0] hdr, input bit dv,
                       input logic [W-1:0] d);
    dif.i_grbx_hdr_valid  = hv;
    dif.i_grbx_hdr        = hdr;
    dif.i_grbx_data_valid = dv;
    dif.i_grbx_data       = d;
  endtask

  task automatic impulse_seq(input string tag);
    drive(1, 2'b10, 1, 32'h0000_0001); step();
    chk({tag, "_w0"}, dif.o_dscr_data, 32'h0000_0001);
    chk({tag, "_w0_first"}, dif.o_dscr_first, 1'b1);
    drive(0, 2'b00, 1, 32'h0); step();
    chk({tag, "_w1"}, dif.o_dscr_data, 32'h0400_0080);
    drive(0, 2'b00, 1, 32'h0); step();
    chk({tag, "_w2"}, dif.o_dscr_data, 32'h0000_0000);
    chk({tag, "_w2_orphan"}, dif.o_dscr_err, 1'b1);
  endtask

  initial begin
    logic [1:0] hl [3];
    i_reset = 1'b1;
    dif.i_rx_lock = 1'b0;
    drive(0, 2'b00, 0, '0);
    step();
    step();
    chk("rst_valid", dif.o_dscr_valid, 1'b0);
    chk("rst_data",  dif.o_dscr_data,  '0);
    i_reset = 1'b0;
    dif.i_rx_lock = 1'b1;

    impulse_seq("impulse");

    // Framing: two good blocks back to back.
    drive(1, 2'b10, 1, $urandom()); step();
    chk("frm_a_first", dif.o_dscr_first, 1'b1);
    drive(0, 2'b00, 1, $urandom()); step();
    chk("frm_b_first", dif.o_dscr_first, 1'b0);
    chk("frm_b_hdr",   dif.o_dscr_hdr,   2'b10);
    chk("frm_b_err",   dif.o_dscr_err,   1'b0);
    drive(1, 2'b01, 1, $urandom()); step();
    drive(0, 2'b00, 1, $urandom()); step();
    chk("frm_01_hdr",  dif.o_dscr_hdr,   2'b01);

    // Bad headers hold err across the block; a good block clears it.
    hl[0] = 2'b00; hl[1] = 2'b11; hl[2] = 2'b01;
    for (int k = 0; k < 3; k++) begin
      drive(1, hl[k], 1, $urandom()); step();
      chk("hdr_err_w0", dif.o_dscr_err, (k < 2));
      drive(0, 2'b00, 1, $urandom()); step();
      chk("hdr_err_w1", dif.o_dscr_err, (k < 2));
    end

    // Orphan word, then abort of a block after word 0 by a lone header.
    drive(0, 2'b00, 1, $urandom()); step();
    chk("orphan_err", dif.o_dscr_err, 1'b1);
    chk("orphan_first", dif.o_dscr_first, 1'b0);
    drive(1, 2'b10, 1, $urandom()); step();
    drive(1, 2'b01, 0, '0); step();
    drive(0, 2'b00, 1, $urandom()); step();
    chk("abort_first", dif.o_dscr_first, 1'b1);
    chk("abort_hdr", dif.o_dscr_hdr, 2'b01);

    // Lock loss mid-block.
    drive(1, 2'b10, 1, $urandom()); step();
    dif.i_rx_lock = 1'b0;
    drive(1, 2'b01, 1, $urandom()); step();
    chk("lock_valid", dif.o_dscr_valid, 1'b0);
    dif.i_rx_lock = 1'b1;
    drive(0, 2'b00, 1, $urandom()); step();
    chk("lock_orphan", dif.o_dscr_err, 1'b1);
    drive(1, 2'b10, 1, $urandom()); step();
    chk("lock_refirst", dif.o_dscr_first, 1'b1);

    // Reset mid-block, then the impulse sequence must repeat exactly.
    drive(0, 2'b00, 1, $urandom()); step();
    i_reset = 1'b1;
    drive(0, 2'b00, 1, $urandom()); step();
    chk("rst_mid_valid", dif.o_dscr_valid, 1'b0);
    chk("rst_mid_first", dif.o_dscr_first, 1'b0);
    chk("rst_mid_hdr",   dif.o_dscr_hdr,   2'b00);
    chk("rst_mid_data",  dif.o_dscr_data,  '0);
    i_reset = 1'b0;
    impulse_seq("impulse_again");

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      i_reset = ($urandom_range(0, 199) == 0);
      dif.i_rx_lock = ($urandom_range(0, 19) != 0);
      drive(($urandom_range(0, 3) == 0), 2'($urandom()),
            ($urandom_range(0, 4) != 0), $urandom());
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
